// File: rtl/call_stack_unit.sv
// Hardware call/return stack for the PC control path: PUSH/POP/CALL/RET with registered pop output.
// Define CALL_STACK_WRAP_EN to get a circular return-address stack that overwrites its oldest entry when full.
module call_stack_unit #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          op_valid,
    input  logic [2:0]    stack_op,
    input  logic [DW-1:0] push_data,
    input  logic [DW-1:0] pc_in,
    input  logic          clr_err,
    output logic [DW-1:0] pop_data,
    output logic          pop_valid,
    output logic          pop_is_ret,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic          underflow
);
    localparam logic [2:0]  OP_PUSH = 3'b001;
    localparam logic [2:0]  OP_POP  = 3'b010;
    localparam logic [2:0]  OP_CALL = 3'b011;
    localparam logic [2:0]  OP_RET  = 3'b100;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    // Handshake: an op is taken on any rising edge with op_valid=1 (never stalls);
    // pop_valid is a one-cycle strobe, no ready, and pop_data/pop_is_ret hold afterwards.
    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   cnt;
    logic          is_push, is_pop, push_ok, pop_ok, ovf_event, unf_event;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] wr_idx, rd_idx;

    assign count   = cnt;
    assign full    = (cnt == DEPTH_C);
    assign empty   = (cnt == '0);
    assign is_push = op_valid && (stack_op == OP_PUSH || stack_op == OP_CALL);
    assign is_pop  = op_valid && (stack_op == OP_POP  || stack_op == OP_RET);
    assign wr_data = (stack_op == OP_CALL) ? pc_in + DW'(1) : push_data;
    assign pop_ok    = is_pop && !empty;
    assign unf_event = is_pop && empty;

`ifdef CALL_STACK_WRAP_EN
    // base marks the oldest entry; a push while full lands on it and retires it.
    logic [AW-1:0] base;

    assign push_ok   = is_push;
    assign ovf_event = 1'b0;
    assign wr_idx    = base + cnt[AW-1:0];
    assign rd_idx    = base + cnt[AW-1:0] - AW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            base <= '0;
        else if (is_push && full)
            base <= base + AW'(1);
    end
`else
    assign push_ok   = is_push && !full;
    assign ovf_event = is_push && full;
    assign wr_idx    = cnt[AW-1:0];
    assign rd_idx    = cnt[AW-1:0] - AW'(1);
`endif

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            pop_data   <= '0;
            pop_valid  <= 1'b0;
            pop_is_ret <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            pop_valid <= pop_ok;
            if (pop_ok) begin
                pop_data   <= mem[rd_idx];
                pop_is_ret <= (stack_op == OP_RET);
                cnt        <= cnt - (AW+1)'(1);
            end else if (push_ok && !full) begin
                cnt <= cnt + (AW+1)'(1);
            end
            // A fresh error in the clearing cycle wins over clr_err.
            overflow  <= (overflow  && !clr_err) || ovf_event;
            underflow <= (underflow && !clr_err) || unf_event;
        end
    end
endmodule

// File: doc/call_stack_unit.md
Name: call_stack_unit

Overview:
- Hardware stack that produces the return address consumed by the PC update logic on RET.
- Serves the StackOp encoding used by the PC block: PUSH, POP, CALL, RET.
- On CALL, stores the return address (pc_in+1). On RET/POP, returns the top entry on pop_data one cycle later, with a pop_valid strobe.
- Sits beside the PC control logic in the multicycle RISC datapath. Replaces the memory-based LMD return path for stack ops.

Parameters:
- DEPTH, 16, number of 32-bit entries (power of 2, >=2)
- AW, 4, log2(DEPTH); index width
- DW, 32, data width of entries and ports

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- op_valid  in  1  stack_op is valid this cycle
- stack_op  in  3  001 PUSH, 010 POP, 011 CALL, 100 RET, others NOP
- push_data  in  DW  data written on PUSH (register value)
- pc_in  in  DW  current PC; CALL writes pc_in+1
- clr_err  in  1  clears sticky overflow/underflow flags
- pop_data  out  DW  entry returned by POP/RET (registered)
- pop_valid  out  1  one-cycle strobe: pop_data is valid
- pop_is_ret  out  1  qualifies pop_valid: 1 = RET, 0 = POP
- count  out  AW+1  number of occupied entries, 0..DEPTH
- full  out  1  count == DEPTH (combinational from count)
- empty  out  1  count == 0 (combinational from count)
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (async, rst=1):
  - count=0, pop_data=0, pop_valid=0, pop_is_ret=0, overflow=0, underflow=0.
  - Storage array is not reset; contents are don't-care.
- Throughput: at most one op per clk. Actions occur only when op_valid=1 at a rising edge. No backpressure; the block is always ready.
- PUSH (001), not full: mem[count] <= push_data; count <= count+1.
- CALL (011), not full: mem[count] <= pc_in+1, truncated to DW bits (0xFFFFFFFF wraps to 0); count <= count+1.
- POP (010) / RET (100), not empty:
  - pop_data <= mem[count-1]; count <= count-1.
  - pop_valid=1 for exactly the next cycle; pop_is_ret=1 for RET, 0 for POP.
  - Latency is 1 cycle from the op edge to pop_valid high.
- PUSH/CALL while full: no write, count unchanged, overflow <= 1.
- POP/RET while empty: count unchanged, pop_valid stays 0, pop_data holds its previous value, underflow <= 1.
- NOP codes (000, 101-111) or op_valid=0: no state change; pop_valid=0.
- Back-to-back ops:
  - PUSH then POP in consecutive cycles returns the just-pushed value; the write is visible to the next cycle.
  - A POP in cycle N+1 may follow a POP in cycle N; each produces its own pop_valid pulse.
- pop_data and pop_is_ret hold their values after pop_valid falls, until the next successful pop.
- clr_err=1 clears both sticky flags. If an error occurs in the same cycle, the new error wins (flag reads 1).
- Reset asserted mid-sequence: all state clears immediately. A pop_valid pending for the next cycle is cancelled.

Optional Feature:
- Macro: CALL_STACK_WRAP_EN.
- Defined: circular return-address-stack mode.
  - A PUSH/CALL while full overwrites the oldest entry via an internal base pointer that advances mod DEPTH.
  - count stays DEPTH; overflow is never set.
  - All indexing is (base + offset) mod DEPTH.
- Not defined: a push while full is rejected and sets overflow, as above. No base pointer exists.
- Underflow behaviour is identical in both modes.

Test Plan:
- Reset, then CALL pc_in=0x10, CALL pc_in=0x40, RET, RET -> pop_data 0x41 then 0x11, pop_is_ret=1 each, count 2->1->0, empty=1.
- PUSH 0xDEADBEEF, POP next cycle -> pop_valid one cycle later with 0xDEADBEEF, pop_is_ret=0, count returns to 0.
- RET on empty -> pop_valid=0, underflow=1, count=0. Then clr_err=1 -> underflow=0. Then clr_err together with another empty POP -> underflow stays 1.
- Fill 16 PUSHes (values 1..16), then PUSH 99:
  - Without the macro: full=1, overflow=1, POP returns 16.
  - With CALL_STACK_WRAP_EN: overflow=0, POPs return 99,16,...,2 (15 pops after 99, then empty).
- CALL with pc_in=0xFFFFFFFF then RET -> pop_data=0x00000000.
- Assert rst asynchronously, mid-clock, between a POP edge and its pop_valid cycle -> pop_valid never rises, count=0, flags=0 immediately.
